fetch_queue: RTL and testbench

- Instruction-side producer for the decode stage.
- Buffers instruction/PC pairs returned by the instruction cache in a small FIFO.
- Drives the decode stage's INSTRUCTION input through an output register that advances only when the downstream pipeline advances.
- Inserts canonical NOPs (ADDI x0,x0,0 = 32'h00000013) on underflow and on FLUSH, so decode never sees stale or garbage words.

---
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch FIFO feeding decode, with NOP insertion on underflow and flush
// Circular buffer of {pc, instruction} pairs behind a single output register that moves only on ADVANCE.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       FETCH_VALID,
   input  logic [31:0]                FETCH_INSTRUCTION,
   input  logic [31:0]                FETCH_PC,
   output logic                       FETCH_READY,
   input  logic                       STALL_ENABLE,
   input  logic                       DATA_CACHE_READY,
   input  logic                       EXSTAGE_STALLED,
   input  logic                       FLUSH,
   output logic [31:0]                INSTRUCTION,
   output logic [31:0]                PC_OUT,
   output logic                       INS_VALID,
   output logic [$clog2(DEPTH):0]     COUNT,
   output logic                       ERR_OVERFLOW
);

   localparam int              AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]   FULL = CW'(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic advance;
   logic push;
   logic pop;
   logic bypass;
   logic wr_en;
   logic empty;

   // Ready is derived from the registered count only, so a same-cycle pop never opens a slot.
   assign FETCH_READY = (COUNT < FULL);
   assign empty       = (COUNT == '0);

   always_comb begin
      advance = STALL_ENABLE & DATA_CACHE_READY & ~EXSTAGE_STALLED;
      push    = FETCH_VALID & FETCH_READY & ~FLUSH;
      pop     = advance & ~empty & ~FLUSH;
      bypass  = advance & empty & push;
      wr_en   = push & ~bypass;
   end

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_ptr] <= {FETCH_PC, FETCH_INSTRUCTION};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         COUNT  <= '0;
      end else if (FLUSH) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         COUNT  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_en && !pop) begin
            COUNT <= COUNT + CW'(1);
         end else if (pop && !wr_en) begin
            COUNT <= COUNT - CW'(1);
         end
      end
   end

   // PC_OUT keeps the last real PC when a bubble is inserted.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         INSTRUCTION <= NOP_WORD;
         PC_OUT      <= '0;
         INS_VALID   <= 1'b0;
      end else if (FLUSH) begin
         INSTRUCTION <= NOP_WORD;
         INS_VALID   <= 1'b0;
      end else if (advance) begin
         if (!empty) begin
            {PC_OUT, INSTRUCTION} <= mem[rd_ptr];
            INS_VALID             <= 1'b1;
         end else if (bypass) begin
            INSTRUCTION <= FETCH_INSTRUCTION;
            PC_OUT      <= FETCH_PC;
            INS_VALID   <= 1'b1;
         end else begin
            INSTRUCTION <= NOP_WORD;
            INS_VALID   <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ERR_OVERFLOW <= 1'b0;
      end else if (FETCH_VALID && !FETCH_READY) begin
         ERR_OVERFLOW <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        CLK = 1'b0;
   logic        RST;
   logic        FETCH_VALID;
   logic [31:0] FETCH_INSTRUCTION;
   logic [31:0] FETCH_PC;
   logic        FETCH_READY;
   logic        STALL_ENABLE;
   logic        DATA_CACHE_READY;
   logic        EXSTAGE_STALLED;
   logic        FLUSH;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC_OUT;
   logic        INS_VALID;
   logic [2:0]  COUNT;
   logic        ERR_OVERFLOW;

   always #5 CLK = ~CLK;

   fetch_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
      .CLK(CLK), .RST(RST),
      .FETCH_VALID(FETCH_VALID), .FETCH_INSTRUCTION(FETCH_INSTRUCTION), .FETCH_PC(FETCH_PC),
      .FETCH_READY(FETCH_READY), .STALL_ENABLE(STALL_ENABLE), .DATA_CACHE_READY(DATA_CACHE_READY),
      .EXSTAGE_STALLED(EXSTAGE_STALLED), .FLUSH(FLUSH), .INSTRUCTION(INSTRUCTION), .PC_OUT(PC_OUT),
      .INS_VALID(INS_VALID), .COUNT(COUNT), .ERR_OVERFLOW(ERR_OVERFLOW)
   );

   int checks   = 0;
   int failures = 0;
   int seq      = 0;

   logic [63:0] exp_q [$];
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_instr = NOP;
      m_pc    = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic model_edge();
      bit ready, adv, psh;
      ready = exp_q.size() < DEPTH;
      adv   = STALL_ENABLE & DATA_CACHE_READY & ~EXSTAGE_STALLED;
      psh   = FETCH_VALID & ready & ~FLUSH;
      if (FETCH_VALID && !ready) m_err = 1'b1;
      if (FLUSH) begin
         exp_q.delete();
         m_instr = NOP;
         m_valid = 1'b0;
      end else if (!adv) begin
         if (psh) exp_q.push_back({FETCH_PC, FETCH_INSTRUCTION});
      end else if (exp_q.size() > 0) begin
         {m_pc, m_instr} = exp_q.pop_front();
         m_valid = 1'b1;
         if (psh) exp_q.push_back({FETCH_PC, FETCH_INSTRUCTION});
      end else if (psh) begin
         m_instr = FETCH_INSTRUCTION;
         m_pc    = FETCH_PC;
         m_valid = 1'b1;
      end else begin
         m_instr = NOP;
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".instr"}, INSTRUCTION, m_instr);
      check({tag, ".pc"}, PC_OUT, m_pc);
      check({tag, ".valid"}, INS_VALID, m_valid);
      check({tag, ".count"}, COUNT, exp_q.size());
      check({tag, ".ready"}, FETCH_READY, exp_q.size() < DEPTH);
      check({tag, ".err"}, ERR_OVERFLOW, m_err);
   endtask

   task automatic step(input string tag);
      @(posedge CLK);
      if (RST) model_reset();
      else model_edge();
      @(negedge CLK);
      compare_all(tag);
   endtask

   task automatic drive(input bit fv, input bit se, input bit dcr, input bit ex, input bit fl);
      seq++;
      FETCH_VALID       = fv;
      FETCH_INSTRUCTION = 32'hA000_0000 | seq;
      FETCH_PC          = 32'h0000_1000 + 32'(seq * 4);
      STALL_ENABLE      = se;
      DATA_CACHE_READY  = dcr;
      EXSTAGE_STALLED   = ex;
      FLUSH             = fl;
   endtask

   initial begin
      RST = 1'b1;
      drive(0, 0, 0, 0, 0);
      model_reset();
      @(negedge CLK);
      compare_all("reset");
      RST = 1'b0;

      // mid-stream asynchronous reset
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, 0);
         step("fill3");
      end
      drive(0, 1, 1, 0, 0);
      #2 RST = 1'b1;
      #1;
      model_reset();
      compare_all("async_rst");
      step("rst_hold");
      RST = 1'b0;

      // bypass into an empty queue
      drive(1, 1, 1, 0, 0);
      FETCH_INSTRUCTION = 32'h00500093;
      FETCH_PC          = 32'h100;
      step("bypass");
      check("bypass_word", INSTRUCTION, 32'h00500093);
      check("bypass_pc", PC_OUT, 32'h100);
      drive(0, 1, 1, 0, 0);
      step("bubble");

      // stall, fill past full, then drain in order
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 1, 0, 0);
         step("stall_fill");
      end
      check("overflow_flag", ERR_OVERFLOW, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 1, 0, 0);
         step("drain");
      end

      // freeze sources
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 1, 0, 0);
         step("fill2");
      end
      drive(0, 1, 0, 0, 0);
      step("freeze_dcache");
      drive(0, 1, 1, 1, 0);
      step("freeze_ex");

      // flush with push and advance in the same cycle
      drive(0, 0, 1, 0, 1);
      step("preflush");
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, 0);
         step("fill3b");
      end
      drive(1, 1, 1, 0, 1);
      step("flush");
      check("flush_nop", INSTRUCTION, NOP);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 0);
         step("post_flush");
      end

      // steady-state push+pop across pointer wrap
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 1, 0, 0);
         step("wrap_fill");
      end
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 1, 0, 0);
         step("wrap");
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 0);
         step("wrap_drain");
      end

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8,
               $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
         step("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
